// File: rtl/slink_app_tx_arbiter.sv
// slink_app_tx_arbiter: priority-qualified round-robin arbiter sharing the a2l channel,
// tagging each payload with its requester index and enforcing a holdoff gap between transfers.
module slink_app_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 24,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         app_clk,
    input  logic                         app_reset,
    input  logic                         enable,
    input  logic [7:0]                   swi_holdoff,
    input  logic [NUM_REQ-1:0]           swi_prio_mask,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         a2l_valid,
    output logic [ID_W+DATA_WIDTH-1:0]   a2l_data,
    input  logic                         a2l_ready,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy
);
    typedef enum logic [1:0] {IDLE, SEND, HOLDOFF} state_t;

    state_t                state;
    logic [7:0]            cnt;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       g;
    logic [NUM_REQ-1:0]    cand;
    logic [DATA_WIDTH-1:0] payload;
    logic                  grant;

    // Nearest set bit after ptr wins: scan from farthest to nearest so the nearest overwrites.
    always_comb begin
        cand = |(req_valid & swi_prio_mask) ? (req_valid & swi_prio_mask) : req_valid;
        g = ptr;
        for (int i = NUM_REQ; i >= 1; i--)
            if (cand[ID_W'((int'(ptr) + i) % NUM_REQ)]) g = ID_W'((int'(ptr) + i) % NUM_REQ);
        payload = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (g == ID_W'(i)) payload = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign grant     = (state == IDLE) && enable && |req_valid && !app_reset;
    assign req_ready = grant ? (NUM_REQ'(1) << g) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge app_clk or posedge app_reset) begin
        if (app_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
            a2l_valid <= 1'b0;
            a2l_data  <= '0;
            grant_id  <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    a2l_data  <= {g, payload};
                    grant_id  <= g;
                    ptr       <= g;
                    a2l_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: if (a2l_ready) begin
                    a2l_valid <= 1'b0;
                    cnt       <= swi_holdoff;
                    state     <= (swi_holdoff == 8'd0) ? IDLE : HOLDOFF;
                end
                HOLDOFF: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
